debug_cmd_receiver: RTL and testbench

- Receive side of the debug-unit UART link: deserialises 8N1 frames from the host on uartRxPin.
- Decodes each byte into a debug command (step, continue, send-registers, halt).
- Presents the command to the debug control FSM through a valid/ready handshake. It is the counterpart of the register-dump transmitter that drives uartTxPin.
- Sits between the pin and the debug FSM, clocked by the datapath clock.

---
 rtl/debug_cmd_receiver.sv | 237 +++++++++++++++++++++++
 tb/tb_debug_cmd_receiver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_receiver.sv
// debug_cmd_receiver
//
// Receive side of the debug-unit UART link. Deserialises 8N1 frames arriving on
// uartRxPin using 16x oversampling, decodes each good byte into one of four debug
// commands and offers it to the debug control FSM over a valid/ready handshake.
//
// Ports
//   clock       system clock, all logic on the rising edge
//   resetGral   asynchronous, active-low reset
//   uartRxPin   asynchronous serial input, idle high
//   cmdReady    debug FSM accepts the pending command
//   cmdValid    a decoded command is pending
//   cmdCode     00 STEP, 01 CONT, 10 SEND, 11 HALT; stable while cmdValid
//   rxData      last correctly framed byte
//   rxValid     one-clock pulse per good frame
//   frameError  one-clock pulse when the stop bit is sampled low
//   unknownCmd  one-clock pulse when a good byte matches no command
//   overrun     sticky; a command arrived while another was still pending

module debug_cmd_receiver #(
  parameter int unsigned CLKS_PER_TICK = 27,
  parameter logic [7:0]  CMD_STEP      = 8'h73,
  parameter logic [7:0]  CMD_CONT      = 8'h63,
  parameter logic [7:0]  CMD_SEND      = 8'h72,
  parameter logic [7:0]  CMD_HALT      = 8'h68
) (
  input  logic       clock,
  input  logic       resetGral,
  input  logic       uartRxPin,
  input  logic       cmdReady,
  output logic       cmdValid,
  output logic [1:0] cmdCode,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       frameError,
  output logic       unknownCmd,
  output logic       overrun
);

  localparam int unsigned TickW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(CLKS_PER_TICK - 1);

  localparam logic [1:0] CodeStep = 2'b00;
  localparam logic [1:0] CodeCont = 2'b01;
  localparam logic [1:0] CodeSend = 2'b10;
  localparam logic [1:0] CodeHalt = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rxState_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser; idles high so a reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic rxMeta;
  logic rxS;

  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= uartRxPin;
      rxS    <= rxMeta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  rxState_e   stateQ, stateD;
  logic [TickW-1:0] tickCntQ, tickCntD;
  logic [3:0] sampleCntQ, sampleCntD;   // ticks elapsed within the current bit
  logic [2:0] bitIdxQ, bitIdxD;
  logic [7:0] shiftQ, shiftD;
  logic [7:0] rxDataD;
  logic       rxValidD;
  logic       frameErrorD;
  logic       tick;

  assign tick = (tickCntQ == TickMax);

  always_comb begin
    stateD      = stateQ;
    tickCntD    = tick ? '0 : tickCntQ + TickW'(1);
    sampleCntD  = tick ? sampleCntQ + 4'd1 : sampleCntQ;
    bitIdxD     = bitIdxQ;
    shiftD      = shiftQ;
    rxDataD     = rxData;
    rxValidD    = 1'b0;
    frameErrorD = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (!rxS) begin
          // Restart the tick phase on the start edge so samples land mid-bit.
          stateD     = StStart;
          tickCntD   = '0;
          sampleCntD = '0;
        end
      end

      StStart: begin
        if (tick && (sampleCntQ == 4'd7)) begin
          tickCntD   = '0;
          sampleCntD = '0;
          if (!rxS) begin
            stateD  = StData;
            bitIdxD = '0;
          end else begin
            // Line went high again before mid start bit: treat as a glitch.
            stateD = StIdle;
          end
        end
      end

      StData: begin
        if (tick && (sampleCntQ == 4'd15)) begin
          shiftD     = {rxS, shiftQ[7:1]};
          bitIdxD    = bitIdxQ + 3'd1;
          sampleCntD = '0;
          if (bitIdxQ == 3'd7) begin
            stateD = StStop;
          end
        end
      end

      StStop: begin
        if (tick && (sampleCntQ == 4'd15)) begin
          stateD     = StIdle;
          sampleCntD = '0;
          if (rxS) begin
            rxDataD  = shiftQ;
            rxValidD = 1'b1;
          end else begin
            frameErrorD = 1'b1;
          end
        end
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      stateQ     <= StIdle;
      tickCntQ   <= '0;
      sampleCntQ <= '0;
      bitIdxQ    <= '0;
      shiftQ     <= '0;
      rxData     <= '0;
      rxValid    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      stateQ     <= stateD;
      tickCntQ   <= tickCntD;
      sampleCntQ <= sampleCntD;
      bitIdxQ    <= bitIdxD;
      shiftQ     <= shiftD;
      rxData     <= rxDataD;
      rxValid    <= rxValidD;
      frameError <= frameErrorD;
    end
  end

  // ---------------------------------------------------------------------------
  // Command decode and handshake. Runs on the clock after rxValid, using the
  // byte that was just latched into rxData.
  // ---------------------------------------------------------------------------
  logic       cmdMatch;
  logic [1:0] matchCode;
  logic       xfer;
  logic       cmdValidD;
  logic [1:0] cmdCodeD;
  logic       unknownCmdD;
  logic       overrunD;

  always_comb begin
    cmdMatch  = 1'b1;
    matchCode = CodeStep;
    if (rxData == CMD_STEP) begin
      matchCode = CodeStep;
    end else if (rxData == CMD_CONT) begin
      matchCode = CodeCont;
    end else if (rxData == CMD_SEND) begin
      matchCode = CodeSend;
    end else if (rxData == CMD_HALT) begin
      matchCode = CodeHalt;
    end else begin
      cmdMatch = 1'b0;
    end
  end

  assign xfer = cmdValid & cmdReady;

  always_comb begin
    cmdValidD   = cmdValid & ~xfer;
    cmdCodeD    = cmdCode;
    overrunD    = overrun;
    unknownCmdD = 1'b0;

    if (rxValid) begin
      if (cmdMatch) begin
        // A command handed over on this same edge frees the slot for the new one.
        if (!cmdValid || xfer) begin
          cmdValidD = 1'b1;
          cmdCodeD  = matchCode;
        end else begin
          overrunD = 1'b1;
        end
      end else begin
        unknownCmdD = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      cmdValid   <= 1'b0;
      cmdCode    <= '0;
      unknownCmd <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cmdValid   <= cmdValidD;
      cmdCode    <= cmdCodeD;
      unknownCmd <= unknownCmdD;
      overrun    <= overrunD;
    end
  end

endmodule

// File: tb/tb_debug_cmd_receiver.sv
// Directed testbench for debug_cmd_receiver with CLKS_PER_TICK = 4 (64 clocks per bit).

module tb_debug_cmd_receiver;

  localparam int unsigned ClksPerTick = 4;
  localparam int unsigned BitClks     = 16 * ClksPerTick;

  logic       clock;
  logic       resetGral;
  logic       uartRxPin;
  logic       cmdReady;
  logic       cmdValid;
  logic [1:0] cmdCode;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameError;
  logic       unknownCmd;
  logic       overrun;

  debug_cmd_receiver #(
    .CLKS_PER_TICK(ClksPerTick)
  ) dut (
    .clock     (clock),
    .resetGral (resetGral),
    .uartRxPin (uartRxPin),
    .cmdReady  (cmdReady),
    .cmdValid  (cmdValid),
    .cmdCode   (cmdCode),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .frameError(frameError),
    .unknownCmd(unknownCmd),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nFails  = 0;

  // Observations gathered while a frame is driven.
  int         nRx;
  int         nFe;
  int         nUnk;
  logic [7:0] rxSeen;
  logic       cvAfter;
  logic [1:0] ccAfter;
  logic       rxPending;
  logic       ackOnRx;

  task automatic clear_obs();
    nRx       = 0;
    nFe       = 0;
    nUnk      = 0;
    rxSeen    = 8'h00;
    cvAfter   = 1'b0;
    ccAfter   = 2'b00;
    rxPending = 1'b0;
  endtask

  // One clock; records pulses and the command state on the clock after rxValid.
  task automatic observe_cycle();
    @(posedge clock);
    #1;
    if (rxPending) begin
      cvAfter   = cmdValid;
      ccAfter   = cmdCode;
      rxPending = 1'b0;
      if (ackOnRx) cmdReady = 1'b0;
    end
    if (rxValid) begin
      nRx++;
      rxSeen    = rxData;
      rxPending = 1'b1;
      // Ack lands on the same edge the new byte is decoded.
      if (ackOnRx) cmdReady = 1'b1;
    end
    if (frameError) nFe++;
    if (unknownCmd) nUnk++;
  endtask

  task automatic drive_bit(input logic v, input int clks);
    uartRxPin = v;
    for (int c = 0; c < clks; c++) observe_cycle();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopBit);
    clear_obs();
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BitClks);
    drive_bit(stopBit, BitClks);
    drive_bit(1'b1, BitClks);
  endtask

  task automatic ack();
    cmdReady = 1'b1;
    @(posedge clock);
    #1;
    cmdReady = 1'b0;
  endtask

  task automatic test_reset();
    resetGral = 1'b0;
    uartRxPin = 1'b1;
    cmdReady  = 1'b0;
    ackOnRx   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    nChecks++; if (cmdValid !== 1'b0) begin nFails++; $display("FAIL reset_cmdValid got %b want 0", cmdValid); end
    nChecks++; if (cmdCode !== 2'b00) begin nFails++; $display("FAIL reset_cmdCode got %b want 00", cmdCode); end
    nChecks++; if (rxData !== 8'h00) begin nFails++; $display("FAIL reset_rxData got %h want 00", rxData); end
    nChecks++; if (rxValid !== 1'b0) begin nFails++; $display("FAIL reset_rxValid got %b want 0", rxValid); end
    nChecks++; if (frameError !== 1'b0) begin nFails++; $display("FAIL reset_frameError got %b want 0", frameError); end
    nChecks++; if (unknownCmd !== 1'b0) begin nFails++; $display("FAIL reset_unknownCmd got %b want 0", unknownCmd); end
    nChecks++; if (overrun !== 1'b0) begin nFails++; $display("FAIL reset_overrun got %b want 0", overrun); end
    resetGral = 1'b1;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic test_step();
    send_frame(8'h73, 1'b1);
    nChecks++; if (nRx !== 1) begin nFails++; $display("FAIL step_rxValid_pulses got %0d want 1", nRx); end
    nChecks++; if (rxSeen !== 8'h73) begin nFails++; $display("FAIL step_rxData got %h want 73", rxSeen); end
    nChecks++; if (cvAfter !== 1'b1) begin nFails++; $display("FAIL step_cmdValid_next got %b want 1", cvAfter); end
    nChecks++; if (ccAfter !== 2'b00) begin nFails++; $display("FAIL step_cmdCode got %b want 00", ccAfter); end
    nChecks++; if (cmdValid !== 1'b1) begin nFails++; $display("FAIL step_cmdValid_hold got %b want 1", cmdValid); end
    ack();
    nChecks++; if (cmdValid !== 1'b0) begin nFails++; $display("FAIL step_ack_clear got %b want 0", cmdValid); end
  endtask

  task automatic test_commands();
    logic [7:0] bytes [3];
    logic [1:0] codes [3];
    bytes[0] = 8'h63; codes[0] = 2'b01;
    bytes[1] = 8'h72; codes[1] = 2'b10;
    bytes[2] = 8'h68; codes[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      send_frame(bytes[k], 1'b1);
      nChecks++; if (cvAfter !== 1'b1) begin nFails++; $display("FAIL cmd%0d_cmdValid got %b want 1", k, cvAfter); end
      nChecks++; if (ccAfter !== codes[k]) begin nFails++; $display("FAIL cmd%0d_cmdCode got %b want %b", k, ccAfter, codes[k]); end
      nChecks++; if ((nFe !== 0) || (nUnk !== 0)) begin nFails++; $display("FAIL cmd%0d_flags got fe=%0d unk=%0d want 0 0", k, nFe, nUnk); end
      ack();
    end
    nChecks++; if (overrun !== 1'b0) begin nFails++; $display("FAIL cmds_overrun got %b want 0", overrun); end
  endtask

  task automatic test_unknown();
    send_frame(8'h41, 1'b1);
    nChecks++; if (nRx !== 1) begin nFails++; $display("FAIL unk_rxValid_pulses got %0d want 1", nRx); end
    nChecks++; if (rxSeen !== 8'h41) begin nFails++; $display("FAIL unk_rxData got %h want 41", rxSeen); end
    nChecks++; if (nUnk !== 1) begin nFails++; $display("FAIL unk_pulses got %0d want 1", nUnk); end
    nChecks++; if (cmdValid !== 1'b0) begin nFails++; $display("FAIL unk_cmdValid got %b want 0", cmdValid); end
  endtask

  task automatic test_frame_error();
    send_frame(8'h73, 1'b0);
    nChecks++; if (nFe !== 1) begin nFails++; $display("FAIL fe_pulses got %0d want 1", nFe); end
    nChecks++; if (nRx !== 0) begin nFails++; $display("FAIL fe_rxValid got %0d want 0", nRx); end
    nChecks++; if (rxData !== 8'h41) begin nFails++; $display("FAIL fe_rxData_kept got %h want 41", rxData); end
    nChecks++; if (cmdValid !== 1'b0) begin nFails++; $display("FAIL fe_cmdValid got %b want 0", cmdValid); end
    send_frame(8'h73, 1'b1);
    nChecks++; if (cvAfter !== 1'b1) begin nFails++; $display("FAIL fe_recover_cmdValid got %b want 1", cvAfter); end
    nChecks++; if (ccAfter !== 2'b00) begin nFails++; $display("FAIL fe_recover_cmdCode got %b want 00", ccAfter); end
    ack();
  endtask

  task automatic test_glitch();
    clear_obs();
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 100);
    nChecks++; if ((nRx !== 0) || (nFe !== 0) || (nUnk !== 0)) begin
      nFails++; $display("FAIL glitch_flags got rx=%0d fe=%0d unk=%0d want 0 0 0", nRx, nFe, nUnk);
    end
    nChecks++; if (cmdValid !== 1'b0) begin nFails++; $display("FAIL glitch_cmdValid got %b want 0", cmdValid); end
  endtask

  task automatic test_simultaneous();
    send_frame(8'h63, 1'b1);
    nChecks++; if (ccAfter !== 2'b01) begin nFails++; $display("FAIL simul_first_code got %b want 01", ccAfter); end
    ackOnRx = 1'b1;
    send_frame(8'h72, 1'b1);
    ackOnRx = 1'b0;
    nChecks++; if (cvAfter !== 1'b1) begin nFails++; $display("FAIL simul_cmdValid got %b want 1", cvAfter); end
    nChecks++; if (ccAfter !== 2'b10) begin nFails++; $display("FAIL simul_cmdCode got %b want 10", ccAfter); end
    nChecks++; if (overrun !== 1'b0) begin nFails++; $display("FAIL simul_overrun got %b want 0", overrun); end
    ack();
    nChecks++; if (cmdValid !== 1'b0) begin nFails++; $display("FAIL simul_ack_clear got %b want 0", cmdValid); end
  endtask

  task automatic test_overrun();
    send_frame(8'h63, 1'b1);
    nChecks++; if (ccAfter !== 2'b01) begin nFails++; $display("FAIL ovr_first_code got %b want 01", ccAfter); end
    send_frame(8'h68, 1'b1);
    nChecks++; if (cmdCode !== 2'b01) begin nFails++; $display("FAIL ovr_code_kept got %b want 01", cmdCode); end
    nChecks++; if (cmdValid !== 1'b1) begin nFails++; $display("FAIL ovr_cmdValid got %b want 1", cmdValid); end
    nChecks++; if (overrun !== 1'b1) begin nFails++; $display("FAIL ovr_flag got %b want 1", overrun); end
    ack();
    nChecks++; if (cmdValid !== 1'b0) begin nFails++; $display("FAIL ovr_ack_clear got %b want 0", cmdValid); end
    nChecks++; if (overrun !== 1'b1) begin nFails++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h73;
    clear_obs();
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 3; i++) drive_bit(b[i], BitClks);
    drive_bit(b[3], 20);
    resetGral = 1'b0;
    #1;
    nChecks++; if ({cmdValid, cmdCode, rxData, rxValid, frameError, unknownCmd, overrun} !== 15'h0) begin
      nFails++;
      $display("FAIL midreset_outputs got cv=%b cc=%b rx=%h rv=%b fe=%b unk=%b ovr=%b want all 0",
               cmdValid, cmdCode, rxData, rxValid, frameError, unknownCmd, overrun);
    end
    uartRxPin = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    resetGral = 1'b1;
    clear_obs();
    drive_bit(1'b1, 100);
    nChecks++; if ((nRx !== 0) || (nFe !== 0)) begin nFails++; $display("FAIL midreset_no_flags got rx=%0d fe=%0d want 0 0", nRx, nFe); end
    send_frame(8'h72, 1'b1);
    nChecks++; if (rxSeen !== 8'h72) begin nFails++; $display("FAIL midreset_rxData got %h want 72", rxSeen); end
    nChecks++; if (cvAfter !== 1'b1) begin nFails++; $display("FAIL midreset_cmdValid got %b want 1", cvAfter); end
    nChecks++; if (ccAfter !== 2'b10) begin nFails++; $display("FAIL midreset_cmdCode got %b want 10", ccAfter); end
    nChecks++; if (overrun !== 1'b0) begin nFails++; $display("FAIL midreset_overrun got %b want 0", overrun); end
    ack();
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_step();
    test_commands();
    test_unknown();
    test_frame_error();
    test_glitch();
    test_simultaneous();
    test_overrun();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
